// File: rtl/rot_pkg.sv
// Shared types and constants for the multi-cycle rotate unit.
package rot_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } rot_state_t;

    localparam logic ROT_LEFT  = 1'b0;
    localparam logic ROT_RIGHT = 1'b1;
    localparam int   ROT_AMT_W = 5;

endpackage

// File: rtl/rot_step.sv
// Combinational single-bit rotate; one step of the iterative rotator.
module rot_step
    import rot_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] work,
    input  logic             dir,
    output logic [WIDTH-1:0] nxt
);

    always_comb begin
        if (dir == ROT_RIGHT) nxt = {work[0], work[WIDTH-1:1]};
        else                  nxt = {work[WIDTH-2:0], work[WIDTH-1]};
    end

endmodule

// File: rtl/rotate_unit.sv
// Iterative 32-bit ROL/ROR, one bit per clock, start/done handshake.
// Optional ROT_SHORTCUT_EN: amounts above WIDTH/2 rotate the other way instead.
module rotate_unit
    import rot_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             start,
    input  logic             dir,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    rot_state_t           state, state_nxt;
    logic [WIDTH-1:0]     work, work_rot;
    logic                 dir_q, dir_eff;
    logic [ROT_AMT_W-1:0] cnt, amt, amt_eff;

    localparam logic [ROT_AMT_W-1:0] ONE = ROT_AMT_W'(1);

    assign amt = b[ROT_AMT_W-1:0];

`ifdef ROT_SHORTCUT_EN
    localparam logic [ROT_AMT_W-1:0] HALF = ROT_AMT_W'(WIDTH / 2);
    localparam logic [ROT_AMT_W:0]   FULL = (ROT_AMT_W + 1)'(WIDTH);
    logic [ROT_AMT_W:0] amt_inv;

    // Rotating by n one way equals rotating by WIDTH-n the other way.
    assign amt_inv = FULL - {1'b0, amt};

    always_comb begin
        dir_eff = dir;
        amt_eff = amt;
        if (amt > HALF) begin
            dir_eff = ~dir;
            amt_eff = amt_inv[ROT_AMT_W-1:0];
        end
    end
`else
    assign dir_eff = dir;
    assign amt_eff = amt;
`endif

    rot_step #(.WIDTH(WIDTH)) u_step (
        .work (work),
        .dir  (dir_q),
        .nxt  (work_rot)
    );

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = (amt == '0) ? DONE : RUN;
            RUN:     if (cnt == ONE) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            work   <= '0;
            dir_q  <= ROT_LEFT;
            cnt    <= '0;
            result <= '0;
        end else begin
            unique case (state)
                IDLE: if (start) begin
                    work  <= a;
                    dir_q <= dir_eff;
                    cnt   <= amt_eff;
                    if (amt == '0) result <= a;
                end
                RUN: begin
                    work <= work_rot;
                    cnt  <= cnt - ONE;
                    if (cnt == ONE) result <= work_rot;
                end
                default: ;
            endcase
        end
    end

    // Decoded straight from the state register, so no input reaches an output combinationally.
    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_rotate_unit.sv
// Scoreboard bench for rotate_unit: directed vectors, monitor checks result and latency on done.
module tb_rotate_unit;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             clear_n = 1'b0;
    logic             start = 1'b0;
    logic             dir = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             busy, done;
    logic [WIDTH-1:0] result;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        logic [WIDTH-1:0] res;
        int               due;
    } exp_t;

    exp_t sb[$];

    rotate_unit #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .clear_n (clear_n),
        .start   (start),
        .dir     (dir),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int steps(input logic [WIDTH-1:0] bv);
        int n;
        n = int'(bv[4:0]);
`ifdef ROT_SHORTCUT_EN
        if (n > 16) n = 32 - n;
`endif
        return n;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (clear_n && done) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 result %h, expected no completion", result);
            end else begin
                e = sb.pop_front();
                check("result", result, e.res);
                check("latency", WIDTH'(cyc), WIDTH'(e.due));
            end
        end
    end

    // Issue one rotate as soon as the unit is idle; leaves us at the negedge after the start edge.
    task automatic issue(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                         input logic dv, input logic [WIDTH-1:0] exp);
        exp_t e;
        int   i;
        @(negedge clk);
        for (i = 0; i < 100 && busy; i++) @(negedge clk);
        if (busy) begin
            n_checks++;
            n_fail++;
            $display("FAIL idle_timeout: got busy=1, expected busy=0 within 100 cycles");
        end
        start = 1'b1;
        a = av;
        b = bv;
        dir = dv;
        e.res = exp;
        e.due = cyc + 1 + steps(bv);
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_drain();
        int i;
        for (i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending, expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #2;
        check("rst_busy", WIDTH'(busy), 0);
        check("rst_done", WIDTH'(done), 0);
        check("rst_result", result, 32'h0);
        @(negedge clk);
        clear_n = 1'b1;

        // n=1 ROL: busy for exactly RUN + DONE.
        issue(32'h8000_0001, 32'd1, 1'b0, 32'h0000_0003);
        check("n1_busy_run", WIDTH'(busy), 1);
        check("n1_done_run", WIDTH'(done), 0);
        @(negedge clk);
        check("n1_busy_done", WIDTH'(busy), 1);
        @(negedge clk);
        check("n1_busy_idle", WIDTH'(busy), 0);
        wait_drain();

        issue(32'h0000_0001, 32'd4, 1'b1, 32'h1000_0000);
        issue(32'hDEAD_BEEF, 32'd0, 1'b0, 32'hDEAD_BEEF);
        issue(32'hDEAD_BEEF, 32'h20, 1'b0, 32'hDEAD_BEEF);
        issue(32'h1234_5678, 32'd28, 1'b0, 32'h8123_4567);
        issue(32'h0000_0001, 32'd31, 1'b1, 32'h0000_0002);
        issue(32'h1234_5678, 32'd16, 1'b0, 32'h5678_1234);
        issue(32'h0001_0000, 32'd17, 1'b1, 32'h8000_0000);
        issue(32'h0000_0001, 32'hFFFF_FFE3, 1'b0, 32'h0000_0008);
        wait_drain();

        // start during RUN must be ignored.
        issue(32'h0000_0001, 32'd10, 1'b0, 32'h0000_0400);
        @(negedge clk);
        start = 1'b1;
        a = 32'hFFFF_0000;
        b = 32'd2;
        dir = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_drain();

        // Clear mid-rotate: 3 of 10 steps done, then discard.
        issue(32'h0000_0001, 32'd10, 1'b0, 32'h0000_0400);
        repeat (3) @(negedge clk);
        #1 clear_n = 1'b0;
        sb.delete();
        #1;
        check("clr_busy", WIDTH'(busy), 0);
        check("clr_done", WIDTH'(done), 0);
        check("clr_result", result, 32'h0);
        @(negedge clk);
        clear_n = 1'b1;
        issue(32'h0000_00F0, 32'd4, 1'b1, 32'h0000_000F);
        wait_drain();

        repeat (5) @(negedge clk);
        check("sb_empty", WIDTH'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
